// File: rtl/oarb.sv
// Output-port arbiter: round-robin grant among input buffer managers, then
// forwards the owner's flit stream to the output queue until its TAIL pops.
//
// state | meaning
// IDLE  | port free, waiting for ready and a request
// GRANT | one-cycle ack to the selected input, HEAD pops
// XFER  | forwarding owner's flits until TAIL is popped
module oarb #(
  parameter int NPORT = 4,
  parameter int DW    = 16,
  // Flit type codes: HEAD=2'b01, BODY=2'b00, TAIL=2'b10; only TAIL matters here.
  parameter logic [1:0] TAIL = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      re,
  input  logic [2*NPORT-1:0]    ptype,
  input  logic [DW*NPORT-1:0]   pdata,
  input  logic                  ready,
  output logic [NPORT-1:0]      ack,
  output logic                  busy,
  output logic [DW+1:0]         dout,
  output logic                  we
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       owner_q, ptr_q, sel;
  logic [NPORT-1:0]    sel_oh, ack_q;
  logic                found, grant;
  logic                re_own, fwd, we_q;
  logic [1:0]          ptype_own;
  logic [DW-1:0]       pdata_own;
  logic [DW+1:0]       dout_q;

  // First requester strictly after the pointer, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    sel    = ptr_q;
    sel_oh = '0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = (int'(ptr_q) + k) % NPORT;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
    sel_oh[sel] = 1'b1;
  end

  always_comb begin
    re_own    = 1'b0;
    ptype_own = '0;
    pdata_own = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (owner_q == PW'(i)) begin
        re_own    = re[i];
        ptype_own = ptype[2*i +: 2];
        pdata_own = pdata[DW*i +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready && found) begin
          grant   = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: state_d = XFER;
      XFER: begin
        if (re_own && ptype_own == TAIL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign fwd  = re_own & busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= PW'(NPORT - 1);
      ack_q   <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (grant) begin
        owner_q <= sel;
        ptr_q   <= sel;
        ack_q   <= sel_oh;
      end
      we_q <= fwd;
      if (fwd) dout_q <= {ptype_own, pdata_own};
    end
  end

  assign ack  = ack_q;
  assign we   = we_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_oarb.sv
// Bench for oarb: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a behavioural arbitration model.
module tb_oarb;
  localparam int NPORT = 4;
  localparam int DW    = 16;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] TAIL = 2'b10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NPORT-1:0]    req_v = '0;
  logic [NPORT-1:0]    re_v = '0;
  logic [2*NPORT-1:0]  ptype_v = '0;
  logic [DW*NPORT-1:0] pdata_v = '0;
  logic                ready_v = 1'b0;
  logic [NPORT-1:0]    ack;
  logic                busy;
  logic [DW+1:0]       dout;
  logic                we;

  int checks = 0;
  int failures = 0;

  // model: phase 0 = free, 1 = granting, 2 = transferring
  int               m_ph, m_own, m_ptr;
  logic [NPORT-1:0] m_ack;
  logic             m_we;
  logic [DW+1:0]    m_dout;

  oarb #(.NPORT(NPORT), .DW(DW), .TAIL(TAIL)) dut (
    .clk(clk), .rst(rst), .req(req_v), .re(re_v), .ptype(ptype_v),
    .pdata(pdata_v), .ready(ready_v), .ack(ack), .busy(busy),
    .dout(dout), .we(we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = 0; m_own = 0; m_ptr = NPORT - 1;
    m_ack = '0; m_we = 1'b0; m_dout = '0;
  endtask

  task automatic m_step();
    logic [1:0] t;
    t = ptype_v[2*m_own +: 2];
    m_we = (m_ph != 0) && re_v[m_own];
    if (m_we) m_dout = {t, pdata_v[DW*m_own +: DW]};
    m_ack = '0;
    if (m_ph == 0) begin
      if (ready_v && req_v != 0) begin
        for (int k = 1; k <= NPORT; k++) begin
          int p;
          p = (m_ptr + k) % NPORT;
          if (req_v[p]) begin
            m_own = p; m_ptr = p; m_ack[p] = 1'b1; m_ph = 1;
            break;
          end
        end
      end
    end else if (m_ph == 1) begin
      m_ph = 2;
    end else if (re_v[m_own] && t == TAIL) begin
      m_ph = 0;
    end
  endtask

  // Inputs already driven; advance one clock and compare at the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst) m_reset(); else m_step();
    @(negedge clk);
    chk("ack", 32'(ack), 32'(m_ack));
    chk("we", 32'(we), 32'(m_we));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("busy", 32'(busy), 32'(m_ph != 0));
  endtask

  task automatic set_flit(input int p, input logic [1:0] t, input logic [DW-1:0] d);
    ptype_v[2*p +: 2] = t;
    pdata_v[DW*p +: DW] = d;
  endtask

  initial begin
    int exp_port;
    m_reset();
    @(negedge clk);

    // 1: reset with all requesting, then first grant to port 0
    req_v = '1; ready_v = 1'b1;
    repeat (3) begin
      cyc();
      chk("t1_rst_ack", 32'(ack), 32'h0);
      chk("t1_rst_we", 32'(we), 32'h0);
    end
    rst = 1'b1;
    cyc();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    re_v = 4'b0001; set_flit(0, HEAD, 16'h1111); req_v = '0;
    cyc();
    chk("t1_ack_off", 32'(ack), 32'h0);
    set_flit(0, TAIL, 16'h1112);
    cyc();
    re_v = '0;
    cyc();

    // 2: single 4-flit packet on input 2
    req_v = 4'b0100;
    cyc();
    chk("t2_ack", 32'(ack), 32'h4);
    req_v = '0; re_v = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      set_flit(2, (k == 0) ? HEAD : (k == 3) ? TAIL : BODY, 16'hA000 + 16'(k));
      cyc();
      chk("t2_we", 32'(we), 32'h1);
      chk("t2_dout", 32'(dout), 32'({((k == 0) ? HEAD : (k == 3) ? TAIL : BODY), 16'hA000 + 16'(k)}));
      if (k == 0) chk("t2_ack_once", 32'(ack), 32'h0);
    end
    chk("t2_busy_drop", 32'(busy), 32'h0);
    re_v = '0;
    cyc();
    chk("t2_we_off", 32'(we), 32'h0);

    // 3: all requesting, 2-flit packets, rotation continues after port 2
    req_v = '1;
    exp_port = 2;
    for (int g = 0; g < 5; g++) begin
      exp_port = (exp_port + 1) % NPORT;
      cyc();
      chk("t3_order", 32'(ack), 32'(1 << exp_port));
      re_v = '0; re_v[exp_port] = 1'b1;
      set_flit(exp_port, HEAD, 16'hB000 + 16'(g));
      cyc();
      set_flit(exp_port, TAIL, 16'hB100 + 16'(g));
      cyc();
      re_v = '0;
      chk("t3_gap_ack", 32'(ack), 32'h0);
    end

    // 4: ready low blocks grants
    req_v = 4'b0001; ready_v = 1'b0;
    repeat (5) begin
      cyc();
      chk("t4_hold", 32'(ack), 32'h0);
    end
    ready_v = 1'b1;
    cyc();
    chk("t4_ack", 32'(ack), 32'h1);

    // 5: bubbles and a stray TAIL pop on a non-owner; ready drop ignored
    req_v = '0; ready_v = 1'b0;
    re_v = 4'b0001; set_flit(0, HEAD, 16'hC000);
    cyc();
    re_v = 4'b1000; set_flit(3, TAIL, 16'hDEAD); set_flit(0, TAIL, 16'hC0FF);
    repeat (2) begin
      cyc();
      chk("t5_bubble_we", 32'(we), 32'h0);
      chk("t5_bubble_busy", 32'(busy), 32'h1);
    end
    re_v = 4'b0001; set_flit(0, BODY, 16'hC001);
    cyc();
    chk("t5_resume", 32'(dout), 32'({BODY, 16'hC001}));
    set_flit(0, TAIL, 16'hC002);
    cyc();
    chk("t5_end", 32'(busy), 32'h0);
    re_v = '0; ready_v = 1'b1;

    // 6: async reset mid-transfer
    req_v = 4'b0100;
    cyc();
    chk("t6_ack", 32'(ack), 32'h4);
    req_v = '0; re_v = 4'b0100;
    set_flit(2, HEAD, 16'hE000);
    cyc();
    set_flit(2, BODY, 16'hE001);
    cyc();
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("t6_rst_we", 32'(we), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_dout", 32'(dout), 32'h0);
    chk("t6_rst_ack", 32'(ack), 32'h0);
    rst = 1'b1;
    re_v = '0; req_v = '1;
    cyc();
    chk("t6_ptr", 32'(ack), 32'h1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_v   = NPORT'($urandom);
      re_v    = NPORT'($urandom);
      ready_v = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NPORT; p++)
        set_flit(p, 2'($urandom_range(0, 2)), DW'($urandom));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
